fpnew_lane_sequencer: RTL and testbench

//  Sequences a vectorial FP op of NUM_LANES=Width/FpWidth lanes over NumPhysLanes physical op units.
//  The op is issued in NUM_BEATS=ceil(NUM_LANES/NumPhysLanes) beats; results are collected into a buffer.

---
 rtl/fpnew_lane_sequencer_if.sv | 27 ++
 rtl/fpnew_lane_sequencer.sv | 171 +++++++++++++++++
 tb/tb_fpnew_lane_sequencer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpnew_lane_sequencer_if.sv
// rtl/fpnew_lane_sequencer_if.sv - beat issue/response bus between the lane sequencer and the unit pool
// Signal names follow the sequencer's point of view; the slave modport is the unit pool.
interface fpnew_lane_sequencer_if #(
   parameter int unsigned FpWidth      = 16,
   parameter int unsigned NumOperands  = 3,
   parameter int unsigned NumPhysLanes = 2
);
   logic [NumPhysLanes*NumOperands*FpWidth-1:0] unit_operands_o;
   logic [NumPhysLanes-1:0]                     unit_lane_en_o;
   logic                                        unit_valid_o;
   logic                                        unit_ready_i;
   logic [NumPhysLanes*FpWidth-1:0]             unit_result_i;
   logic [NumPhysLanes*5-1:0]                   unit_status_i;
   logic                                        unit_ext_bit_i;
   logic                                        unit_valid_i;
   logic                                        unit_ready_o;

   modport master (
      output unit_operands_o, unit_lane_en_o, unit_valid_o, unit_ready_o,
      input  unit_ready_i, unit_result_i, unit_status_i, unit_ext_bit_i, unit_valid_i
   );

   modport slave (
      input  unit_operands_o, unit_lane_en_o, unit_valid_o, unit_ready_o,
      output unit_ready_i, unit_result_i, unit_status_i, unit_ext_bit_i, unit_valid_i
   );
endinterface

// File: rtl/fpnew_lane_sequencer.sv
// rtl/fpnew_lane_sequencer.sv - issues a vectorial FP op over a narrow unit pool in beats
// Results are gathered into a lane buffer; lanes never written are boxed with the first beat's ext bit.
module fpnew_lane_sequencer #(
   parameter int unsigned Width         = 64,
   parameter int unsigned FpWidth       = 16,
   parameter int unsigned NumOperands   = 3,
   parameter int unsigned NumPhysLanes  = 2,
   parameter int unsigned TagWidth      = 8,
   parameter bit          EnableVectors = 1'b1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumOperands*Width-1:0]  operands_i,
   input  logic                          vectorial_op_i,
   input  logic [TagWidth-1:0]           tag_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic                          flush_i,
   fpnew_lane_sequencer_if.master        unit,
   output logic [Width-1:0]              result_o,
   output logic [4:0]                    status_o,
   output logic                          extension_bit_o,
   output logic [TagWidth-1:0]           tag_o,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic                          busy_o
);
   localparam int unsigned NumLanes = Width / FpWidth;
   localparam int unsigned NumBeats = (NumLanes + NumPhysLanes - 1) / NumPhysLanes;
   localparam int unsigned CntWidth = $clog2(NumBeats + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e                       state_q, state_d;
   logic [CntWidth-1:0]          issue_cnt_q, issue_cnt_d;
   logic [CntWidth-1:0]          resp_cnt_q, resp_cnt_d;
   logic [CntWidth-1:0]          num_beats;
   logic [NumOperands*Width-1:0] ops_q, ops_d;
   logic [TagWidth-1:0]          tag_q, tag_d;
   logic                         vec_q, vec_d;
   logic [NumLanes*FpWidth-1:0]  buf_q, buf_d;
   logic [NumLanes-1:0]          written_q, written_d;
   logic [4:0]                   status_q, status_d;
   logic                         ext_q, ext_d;

   function automatic int unsigned lane_of(logic [CntWidth-1:0] beat, int unsigned phys);
      return 32'(beat) * NumPhysLanes + phys;
   endfunction

   // Scalar ops only ever carry logical lane 0.
   function automatic logic lane_live(int unsigned lane, logic vec);
      return (lane < NumLanes) && (vec || lane == 0);
   endfunction

   assign num_beats = vec_q ? CntWidth'(NumBeats) : CntWidth'(1);

   always_comb begin
      state_d              = state_q;
      issue_cnt_d          = issue_cnt_q;
      resp_cnt_d           = resp_cnt_q;
      ops_d                = ops_q;
      tag_d                = tag_q;
      vec_d                = vec_q;
      buf_d                = buf_q;
      written_d            = written_q;
      status_d             = status_q;
      ext_d                = ext_q;
      in_ready_o           = 1'b0;
      out_valid_o          = 1'b0;
      unit.unit_valid_o    = 1'b0;
      unit.unit_ready_o    = 1'b0;
      unit.unit_lane_en_o  = '0;
      unit.unit_operands_o = '0;

      case (state_q)
         IDLE: in_ready_o = 1'b1;
         RUN: begin
            unit.unit_valid_o = (issue_cnt_q < num_beats);
            unit.unit_ready_o = 1'b1;
            for (int unsigned p = 0; p < NumPhysLanes; p++) begin
               for (int unsigned l = 0; l < NumLanes; l++) begin
                  if (l == lane_of(issue_cnt_q, p) && lane_live(l, vec_q)) begin
                     unit.unit_lane_en_o[p] = 1'b1;
                     for (int unsigned i = 0; i < NumOperands; i++)
                        unit.unit_operands_o[(p*NumOperands+i)*FpWidth +: FpWidth] =
                           ops_q[i*Width + l*FpWidth +: FpWidth];
                  end
               end
            end
            if (unit.unit_valid_o && unit.unit_ready_i) issue_cnt_d = issue_cnt_q + 1'b1;

            if (unit.unit_valid_i) begin
               for (int unsigned p = 0; p < NumPhysLanes; p++) begin
                  for (int unsigned l = 0; l < NumLanes; l++) begin
                     if (l == lane_of(resp_cnt_q, p) && lane_live(l, vec_q)) begin
                        buf_d[l*FpWidth +: FpWidth] = unit.unit_result_i[p*FpWidth +: FpWidth];
                        written_d[l]                = 1'b1;
                        status_d                    = status_d | unit.unit_status_i[p*5 +: 5];
                     end
                  end
               end
               if (resp_cnt_q == '0) ext_d = unit.unit_ext_bit_i;
               resp_cnt_d = resp_cnt_q + 1'b1;
               if (resp_cnt_d == num_beats) state_d = DONE;
            end
         end
         DONE: begin
            out_valid_o = 1'b1;
            in_ready_o  = out_ready_i;
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush_i) in_ready_o = 1'b0;

      if (in_valid_i && in_ready_o) begin
         ops_d       = operands_i;
         tag_d       = tag_i;
         vec_d       = vectorial_op_i & EnableVectors;
         issue_cnt_d = '0;
         resp_cnt_d  = '0;
         status_d    = '0;
         written_d   = '0;
         state_d     = RUN;
      end

      if (flush_i) begin
         state_d     = IDLE;
         issue_cnt_d = '0;
         resp_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         issue_cnt_q <= '0;
         resp_cnt_q  <= '0;
         ops_q       <= '0;
         tag_q       <= '0;
         vec_q       <= 1'b0;
         buf_q       <= '0;
         written_q   <= '0;
         status_q    <= '0;
         ext_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         resp_cnt_q  <= resp_cnt_d;
         ops_q       <= ops_d;
         tag_q       <= tag_d;
         vec_q       <= vec_d;
         buf_q       <= buf_d;
         written_q   <= written_d;
         status_q    <= status_d;
         ext_q       <= ext_d;
      end
   end

   always_comb begin
      result_o = '0;
      for (int unsigned l = 0; l < NumLanes; l++)
         result_o[l*FpWidth +: FpWidth] = written_q[l] ? buf_q[l*FpWidth +: FpWidth] : {FpWidth{ext_q}};
   end

   assign busy_o          = (state_q != IDLE);
   assign status_o        = status_q;
   assign tag_o           = tag_q;
   assign extension_bit_o = ext_q;
endmodule

// File: tb/tb_fpnew_lane_sequencer.sv
// tb/tb_fpnew_lane_sequencer.sv - scoreboard bench for fpnew_lane_sequencer
// A 1-cycle stub unit echoes op0 lanes, reports op1[4:0] as status and op2 bit 0 of lane 0 as ext bit.
module tb_fpnew_lane_sequencer;
   localparam int W  = 64;
   localparam int FW = 16;
   localparam int NO = 3;
   localparam int NP = 2;
   localparam int TW = 8;
   localparam int NL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NO*W-1:0] operands = '0;
   logic            vec = 1'b0;
   logic [TW-1:0]   tag = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            flush = 1'b0;
   logic [W-1:0]    result;
   logic [4:0]      status;
   logic            ext_bit;
   logic [TW-1:0]   tag_out;
   logic            out_valid;
   logic            out_rdy = 1'b1;
   logic            busy;
   logic            unit_rdy = 1'b1;
   logic            rand_bp = 1'b0;

   fpnew_lane_sequencer_if #(.FpWidth(FW), .NumOperands(NO), .NumPhysLanes(NP)) u_if ();

   fpnew_lane_sequencer #(.Width(W), .FpWidth(FW), .NumOperands(NO), .NumPhysLanes(NP),
                          .TagWidth(TW), .EnableVectors(1'b1)) u_dut (
      .clk_i(clk), .rst_i(rst), .operands_i(operands), .vectorial_op_i(vec), .tag_i(tag),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush), .unit(u_if),
      .result_o(result), .status_o(status), .extension_bit_o(ext_bit), .tag_o(tag_out),
      .out_valid_o(out_valid), .out_ready_i(out_rdy), .busy_o(busy)
   );

   // Stub unit pool: garbage on disabled lanes so the DUT must mask them.
   logic              st_valid;
   logic [NP*FW-1:0]  st_result;
   logic [NP*5-1:0]   st_status;
   logic              st_ext;
   assign u_if.unit_ready_i   = unit_rdy;
   assign u_if.unit_valid_i   = st_valid;
   assign u_if.unit_result_i  = st_result;
   assign u_if.unit_status_i  = st_status;
   assign u_if.unit_ext_bit_i = st_ext;

   always @(posedge clk) begin
      if (rst || flush) st_valid <= 1'b0;
      else begin
         if (st_valid && u_if.unit_ready_o) st_valid <= 1'b0;
         if (u_if.unit_valid_o && unit_rdy) begin
            st_valid <= 1'b1;
            st_ext   <= u_if.unit_operands_o[2*FW];
            for (int p = 0; p < NP; p++) begin
               st_result[p*FW +: FW] <= u_if.unit_lane_en_o[p] ? u_if.unit_operands_o[p*NO*FW +: FW] : 16'hDEAD;
               st_status[p*5 +: 5]   <= u_if.unit_lane_en_o[p] ? u_if.unit_operands_o[(p*NO+1)*FW +: 5] : 5'h1F;
            end
         end
      end
   end

   // Second instance with three physical lanes.
   logic [NO*W-1:0] operands3 = '0;
   logic            in_valid3 = 1'b0;
   logic            in_ready3, out_valid3, busy3, ext3;
   logic [W-1:0]    result3;
   logic [4:0]      status3;
   logic [TW-1:0]   tag3_out;
   logic            st3_valid;
   logic [3*FW-1:0] st3_result;

   fpnew_lane_sequencer_if #(.FpWidth(FW), .NumOperands(NO), .NumPhysLanes(3)) u_if3 ();

   fpnew_lane_sequencer #(.Width(W), .FpWidth(FW), .NumOperands(NO), .NumPhysLanes(3),
                          .TagWidth(TW), .EnableVectors(1'b1)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .operands_i(operands3), .vectorial_op_i(1'b1), .tag_i(8'h5A),
      .in_valid_i(in_valid3), .in_ready_o(in_ready3), .flush_i(1'b0), .unit(u_if3),
      .result_o(result3), .status_o(status3), .extension_bit_o(ext3), .tag_o(tag3_out),
      .out_valid_o(out_valid3), .out_ready_i(1'b1), .busy_o(busy3)
   );

   assign u_if3.unit_ready_i   = 1'b1;
   assign u_if3.unit_valid_i   = st3_valid;
   assign u_if3.unit_result_i  = st3_result;
   assign u_if3.unit_status_i  = '0;
   assign u_if3.unit_ext_bit_i = 1'b0;

   always @(posedge clk) begin
      if (rst) st3_valid <= 1'b0;
      else begin
         st3_valid <= u_if3.unit_valid_o;
         for (int p = 0; p < 3; p++)
            st3_result[p*FW +: FW] <= u_if3.unit_lane_en_o[p] ? u_if3.unit_operands_o[p*NO*FW +: FW] : 16'hDEAD;
      end
   end

   typedef struct packed {
      logic [W-1:0]  result;
      logic [4:0]    status;
      logic          ext;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: live lanes echo op0 and OR in op1[4:0]; dead lanes are boxed with the ext bit.
   function automatic exp_t model(input logic [NO*W-1:0] ops, input logic v, input logic [TW-1:0] t);
      exp_t e;
      e.tag    = t;
      e.ext    = ops[2*W];
      e.status = '0;
      e.result = '0;
      for (int l = 0; l < NL; l++) begin
         if (v || l == 0) begin
            e.result[l*FW +: FW] = ops[l*FW +: FW];
            e.status = e.status | ops[W + l*FW +: 5];
         end else begin
            e.result[l*FW +: FW] = {FW{e.ext}};
         end
      end
      return e;
   endfunction

   logic [NO*W-1:0]    iss_ops = '0;
   logic               iss_vec = 1'b0;
   int                 iss_beat = 0;
   logic [NP-1:0]      exp_en;
   logic [NP*NO*FW-1:0] exp_opnds;
   exp_t               popped;

   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         iss_beat = 0;
      end else begin
         if (u_if.unit_valid_o && unit_rdy) begin
            exp_en    = '0;
            exp_opnds = '0;
            for (int p = 0; p < NP; p++) begin
               if (iss_beat*NP + p < NL && (iss_vec || iss_beat*NP + p == 0)) begin
                  exp_en[p] = 1'b1;
                  for (int i = 0; i < NO; i++)
                     exp_opnds[(p*NO+i)*FW +: FW] = iss_ops[i*W + (iss_beat*NP+p)*FW +: FW];
               end
            end
            check("issue_lane_en", 192'(u_if.unit_lane_en_o), 192'(exp_en));
            check("issue_operands", 192'(u_if.unit_operands_o), 192'(exp_opnds));
            iss_beat++;
         end
         if (out_valid && out_rdy && !flush) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_output: result %0h with empty scoreboard", result);
            end else begin
               popped = sb_q.pop_front();
               check("result", 192'(result), 192'(popped.result));
               check("status", 192'(status), 192'(popped.status));
               check("ext_bit", 192'(ext_bit), 192'(popped.ext));
               check("tag", 192'(tag_out), 192'(popped.tag));
            end
         end
         if (flush && busy && sb_q.size() > 0) void'(sb_q.pop_back());
         if (in_valid && in_ready && !flush) begin
            sb_q.push_back(model(operands, vec, tag));
            iss_ops  = operands;
            iss_vec  = vec;
            iss_beat = 0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) begin
            unit_rdy = ($urandom_range(0, 3) != 0);
            out_rdy  = ($urandom_range(0, 2) != 0);
         end
      end
   end

   task automatic send(input logic [NO*W-1:0] ops, input logic v, input logic [TW-1:0] t, output logic in_done);
      bit got = 0;
      operands = ops;
      vec      = v;
      tag      = t;
      in_valid = 1'b1;
      in_done  = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (in_ready && !flush) begin
            got     = 1;
            in_done = out_valid;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: in_ready %0b after 300 cycles, required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cycles);
      cycles = -1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (out_valid) begin
            cycles = k;
            break;
         end
      end
      if (cycles < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL out_timeout: out_valid %0b after 300 cycles, required 1", out_valid);
      end
   endtask

   task automatic wait_idle();
      bit got = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (!busy && sb_q.size() == 0) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL idle_timeout: busy %0b pending %0d, required 0/0", busy, sb_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_in_ready"}, 192'(in_ready), 192'(1));
      check({pfx, "_out_valid"}, 192'(out_valid), 192'(0));
      check({pfx, "_busy"}, 192'(busy), 192'(0));
      check({pfx, "_unit_valid"}, 192'(u_if.unit_valid_o), 192'(0));
      check({pfx, "_result"}, 192'(result), 192'(0));
      check({pfx, "_status"}, 192'(status), 192'(0));
      check({pfx, "_tag"}, 192'(tag_out), 192'(0));
      check({pfx, "_ext"}, 192'(ext_bit), 192'(0));
   endtask

   function automatic logic [NO*W-1:0] rand_ops();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   logic            done_flag;
   int              lat;
   logic [NO*W-1:0] ops;
   logic [2:0]      en3 [2];
   int              b3;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;

      // Scalar op, ext bit set, latency from the accept cycle.
      ops = {64'h0000_0000_0000_0001, 64'h0, 64'h1234_5678_9ABC_3C00};
      send(ops, 1'b0, 8'h11, done_flag);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) check("scalar_lane_en", 192'(u_if.unit_lane_en_o), 192'(2'b01));
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      check("scalar_latency", 192'(lat), 192'(3));
      check("scalar_result", 192'(result), 192'(64'hFFFF_FFFF_FFFF_3C00));
      wait_idle();

      // Vector op: NX from lane 2, OF from lane 3.
      ops = {64'h0, 64'h0004_0001_0000_0000, 64'h4444_3333_2222_1111};
      send(ops, 1'b1, 8'h22, done_flag);
      wait_out(lat);
      check("vector_result", 192'(result), 192'(64'h4444_3333_2222_1111));
      check("vector_status", 192'(status), 192'(5'b00101));
      wait_idle();

      // Unit and downstream backpressure.
      unit_rdy = 1'b0;
      out_rdy  = 1'b0;
      ops = rand_ops();
      send(ops, 1'b1, 8'h33, done_flag);
      repeat (5) begin
         @(negedge clk);
         check("stall_unit_valid", 192'(u_if.unit_valid_o), 192'(1));
         check("stall_in_ready", 192'(in_ready), 192'(0));
      end
      @(posedge clk);
      #1;
      unit_rdy = 1'b1;
      wait_out(lat);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         check("hold_out_valid", 192'(out_valid), 192'(1));
         check("hold_in_ready", 192'(in_ready), 192'(0));
         check("hold_result", 192'(result), 192'(model(ops, 1'b1, 8'h33).result));
      end
      @(posedge clk);
      #1;
      out_rdy = 1'b1;
      wait_idle();

      // Flush after beat 0 has issued.
      send(rand_ops(), 1'b1, 8'h44, done_flag);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("flush_busy", 192'(busy), 192'(0));
         check("flush_out_valid", 192'(out_valid), 192'(0));
      end
      @(posedge clk);
      #1;
      send(rand_ops(), 1'b1, 8'h45, done_flag);
      wait_idle();

      // Back-to-back: the second op is taken in the DONE cycle of the first.
      send(rand_ops(), 1'b1, 8'h55, done_flag);
      send(rand_ops(), 1'b0, 8'h56, done_flag);
      check("b2b_accept_in_done", 192'(done_flag), 192'(1));
      @(negedge clk);
      check("b2b_busy", 192'(busy), 192'(1));
      wait_idle();

      // Randomised traffic with random backpressure.
      rand_bp = 1'b1;
      for (int n = 0; n < 40; n++)
         send(rand_ops(), 1'($urandom_range(0, 1)), 8'($urandom), done_flag);
      rand_bp = 1'b0;
      @(posedge clk);
      #1;
      unit_rdy = 1'b1;
      out_rdy  = 1'b1;
      wait_idle();

      // Three physical lanes: second beat carries only lane 3.
      operands3 = rand_ops();
      in_valid3 = 1'b1;
      @(negedge clk);
      check("np3_in_ready", 192'(in_ready3), 192'(1));
      @(posedge clk);
      #1;
      in_valid3 = 1'b0;
      b3 = 0;
      en3[0] = '0;
      en3[1] = '0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (u_if3.unit_valid_o && b3 < 2) begin
            en3[b3] = u_if3.unit_lane_en_o;
            b3++;
         end
         if (out_valid3) break;
      end
      check("np3_beats", 192'(b3), 192'(2));
      check("np3_beat0_en", 192'(en3[0]), 192'(3'b111));
      check("np3_beat1_en", 192'(en3[1]), 192'(3'b001));
      check("np3_out_valid", 192'(out_valid3), 192'(1));
      check("np3_result", 192'(result3), 192'(operands3[W-1:0]));
      @(posedge clk);
      #1;

      // Reset in the middle of RUN.
      send(rand_ops(), 1'b1, 8'h77, done_flag);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrun_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish within 400000 time units");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1);
   end
endmodule
